layer_code: RTL and testbench
=============================

LAYER_CODE -- requirements
Module: layer_code

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_in  input  1  synchronous active-high reset.
REQ-004 t0h_cnt_in / t0l_cnt_in / t1h_cnt_in / t1l_cnt_in  input  8 each  phase lengths for '0' high, '0' low, '1' high and '1' low.
REQ-005 rst_cnt_in  input  16  length of the latch (reset) gap after a frame.
REQ-006 data_valid_in  input  1  pixel word offered.
REQ-007 data_in  input  24  pixel word, GRB order, sent MSB first.
REQ-008 last_in  input  1  offered pixel is the last of its frame.
REQ-009 data_ready_out  output  1  pixel accepted when data_valid_in and data_ready_out are both high.
REQ-010 bit_code_out  output  1  registered serial line drive.
REQ-011 busy_out  output  1  high in any state other than IDLE.
REQ-012 done_out  output  1  one-cycle pulse when a frame's latch gap completes.

Function
REQ-013 The state machine SHALL have four states: IDLE, HIGH, LOW and LATCH.
REQ-014 IDLE: bit_code_out=0, data_ready_out=1; on handshake it latches data_in and last_in, sets bit index to 23 and enters HIGH.
REQ-015 Handshake in cycle N SHALL give bit_code_out=1 from cycle N+1; single-cycle latency.
REQ-016 On HIGH entry, the block SHALL latch the high and low counts for the current bit (bit value selects t1* or t0*), and the latched pair SHALL apply to the whole bit.
REQ-017 A phase with count value C SHALL last C+1 clocks, so C=0 gives 1 clock and C=255 gives 256 clocks.
REQ-018 HIGH: bit_code_out=1 for the latched high length, then the block enters LOW.
REQ-019 LOW: bit_code_out=0 for the latched low length; then, if bit index>0, the index decrements and the block re-enters HIGH.
REQ-020 At the end of LOW on bit 0 with last=1, the block SHALL enter LATCH.
REQ-021 During the final LOW cycle of bit 0 with last=0, data_ready_out SHALL be 1.
- On handshake in that cycle, the next pixel's HIGH starts on the next clock with no gap.
- Otherwise the block enters IDLE, with the line held 0 (underrun stretches the low time).
REQ-022 LATCH: bit_code_out=0 for rst_cnt_in+1 clocks, with rst_cnt_in sampled at LATCH entry.
REQ-023 done_out SHALL pulse in the final LATCH cycle, and the block SHALL enter IDLE on the next clock.
REQ-024 data_ready_out SHALL be 0 in HIGH, LATCH and LOW, except in the cycle given in REQ-021.
REQ-025 The phase counter SHALL be 16 bits, load length-1 and count down to 0.
REQ-026 The bit index SHALL be 5 bits; no wrap beyond bit 0.
REQ-027 Changes to the count inputs mid-phase SHALL NOT affect the phase in progress.

Reset
REQ-028 While rst_in is high, the block SHALL hold state=IDLE and bit_code_out=0.
REQ-029 While rst_in is high, data_ready_out, busy_out and done_out SHALL be 0, and counters and data latch SHALL be cleared.
REQ-030 Reset asserted mid-bit or mid-LATCH SHALL drive bit_code_out=0 on the next clock and abandon the pixel.
REQ-031 data_ready_out SHALL return to 1 in the first cycle after rst_in deasserts.

Structure
REQ-032 A shared package layer_pkg SHALL hold the state enum typedef, PIXEL_BITS=24, CNT_W=8 and RST_W=16.
REQ-033 layer_code SHALL be a single module with no sub-module; the phase counter and bit index live in the same sequential process as the state register.

Verification
REQ-034 Single pixel: counts t0h=2, t0l=5, t1h=5, t1l=2, rst=10; handshake at cycle 0 with data 24'h800001, last=1.
- Bit 23 is high for cycles 1-6 and low for 7-9; bit 22 is high for 10-12 and low for 13-18.
- The pixel ends at cycle 216; LATCH runs for cycles 217-227, done_out=1 at 227, data_ready_out=1 at 228.
REQ-035 Back-to-back: two pixels, the first with last=0 and valid held high. The second handshake lands in cycle 216, the second pixel's bit 23 goes high at cycle 217, and there is no IDLE cycle.
REQ-036 Underrun: a pixel with last=0 and no following valid. The line stays 0 and busy_out=0; a later handshake at cycle M gives a high at M+1.
REQ-037 All counts 0, pixel 24'hAAAAAA, last=1: each bit is 1 clock high and 1 clock low, and LATCH lasts 1 clock (done_out at cycle 49).
REQ-038 Mid-phase changes: change t1h from 5 to 1 in the third cycle of a '1' high phase. The current high still lasts 6 clocks and the next '1' bit is high for 2.
REQ-039 Mid-operation reset: rst_in high for 2 cycles during LOW of bit 12. bit_code_out is 0 and data_ready_out is 0 during reset, data_ready_out is 1 after it, and no done_out pulse occurs.

Source files
------------

// File: rtl/layer_code_pkg.sv
// Shared types and sizes for the serial pixel line coder.
// Imported by the interface and the coder itself.
package layer_pkg;
    localparam int PIXEL_BITS = 24;
    localparam int CNT_W      = 8;
    localparam int RST_W      = 16;
    localparam int PH_W       = 16;
    localparam int IDX_W      = 5;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;
endpackage

// File: rtl/layer_code_if.sv
// Pixel word handshake between a pixel source and the line coder.
// The source drives valid/data/last; the coder drives ready.
interface layer_code_if;
    import layer_pkg::*;

    logic                  data_valid_in;
    logic [PIXEL_BITS-1:0] data_in;
    logic                  last_in;
    logic                  data_ready_out;

    modport master (
        output data_valid_in,
        output data_in,
        output last_in,
        input  data_ready_out
    );

    modport slave (
        input  data_valid_in,
        input  data_in,
        input  last_in,
        output data_ready_out
    );
endinterface

// File: rtl/layer_code.sv
// Serialises 24-bit GRB pixels into a one-wire pulse-width code,
// followed by a latch gap at the end of each frame.
module layer_code
    import layer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [CNT_W-1:0] t0h_cnt_in,
    input  logic [CNT_W-1:0] t0l_cnt_in,
    input  logic [CNT_W-1:0] t1h_cnt_in,
    input  logic [CNT_W-1:0] t1l_cnt_in,
    input  logic [RST_W-1:0] rst_cnt_in,
    layer_code_if.slave      px,
    output logic             bit_code_out,
    output logic             busy_out,
    output logic             done_out
);

    state_t                state;
    logic [PH_W-1:0]       cnt;
    logic [CNT_W-1:0]      lo_len;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_m1;
    logic [PIXEL_BITS-1:0] data;
    logic                  last;

    logic                  end_ph;
    logic                  ready;
    logic                  take;
    logic                  nb;
    logic [CNT_W-1:0]      hi_sel;
    logic [CNT_W-1:0]      lo_sel;

    assign end_ph = (cnt == '0);
    assign idx_m1 = idx - IDX_W'(1);

    // Ready in IDLE, and in the final low cycle of a non-last pixel
    // so the next pixel can follow without a gap.
    assign ready = !rst_in &&
                   ((state == IDLE) ||
                    (state == LOW && end_ph && idx == '0 && !last));
    assign take  = ready && px.data_valid_in;

    assign px.data_ready_out = ready;
    assign busy_out = !rst_in && (state != IDLE);
    assign done_out = !rst_in && (state == LATCH) && end_ph;

    // Value of the bit about to start: new pixel MSB or next index.
    always_comb begin
        nb     = take ? px.data_in[PIXEL_BITS-1] : data[idx_m1];
        hi_sel = nb ? t1h_cnt_in : t0h_cnt_in;
        lo_sel = nb ? t1l_cnt_in : t0l_cnt_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            bit_code_out <= 1'b0;
            cnt          <= '0;
            lo_len       <= '0;
            idx          <= '0;
            data         <= '0;
            last         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                HIGH: begin
                    if (end_ph) begin
                        state        <= LOW;
                        bit_code_out <= 1'b0;
                        cnt          <= PH_W'(lo_len);
                    end else begin
                        cnt <= cnt - PH_W'(1);
                    end
                end
                LOW: begin
                    if (!end_ph) begin
                        cnt <= cnt - PH_W'(1);
                    end else if (idx != '0) begin
                        idx          <= idx_m1;
                        state        <= HIGH;
                        bit_code_out <= 1'b1;
                        cnt          <= PH_W'(hi_sel);
                        lo_len       <= lo_sel;
                    end else if (last) begin
                        state <= LATCH;
                        cnt   <= rst_cnt_in;
                    end else begin
                        state <= IDLE;
                    end
                end
                LATCH: begin
                    if (end_ph) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - PH_W'(1);
                    end
                end
            endcase

            // Accepting a pixel overrides the IDLE fall-through above.
            if (take) begin
                data         <= px.data_in;
                last         <= px.last_in;
                idx          <= IDX_W'(PIXEL_BITS - 1);
                state        <= HIGH;
                bit_code_out <= 1'b1;
                cnt          <= PH_W'(hi_sel);
                lo_len       <= lo_sel;
            end
        end
    end

endmodule

// File: tb/tb_layer_code.sv
// Bench for layer_code: a cycle-accurate expected stream is built
// from the pulse-code rules, then replayed against the coder.
module tb_layer_code;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  t0h, t0l, t1h, t1l;
    logic [15:0] rcnt;
    logic        line, busy, done;

    layer_code_if px ();

    layer_code dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .t0h_cnt_in   (t0h),
        .t0l_cnt_in   (t0l),
        .t1h_cnt_in   (t1h),
        .t1l_cnt_in   (t1l),
        .rst_cnt_in   (rcnt),
        .px           (px),
        .bit_code_out (line),
        .busy_out     (busy),
        .done_out     (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit        v;
        bit [23:0] d;
        bit        l;
        bit        line;
        bit        busy;
        bit        rdy;
        bit        dn;
    } cyc_t;

    cyc_t      q[$];
    bit [23:0] pd[4];
    int        gp[4];

    task automatic push(input bit ln, input bit b, input bit r);
        cyc_t c;
        c.v = 0; c.d = '0; c.l = 0;
        c.line = ln; c.busy = b; c.rdy = r; c.dn = 0;
        q.push_back(c);
    endtask

    task automatic idle(input int n);
        repeat (n) push(0, 0, 1);
    endtask

    task automatic hs(input bit [23:0] d, input bit l);
        q[q.size()-1].v = 1;
        q[q.size()-1].d = d;
        q[q.size()-1].l = l;
    endtask

    // Each bit: (high count + 1) clocks at 1, (low count + 1) at 0.
    task automatic bits(input bit [23:0] d, input bit l);
        for (int b = 23; b >= 0; b--) begin
            int h  = d[b] ? int'(t1h) : int'(t0h);
            int lw = d[b] ? int'(t1l) : int'(t0l);
            repeat (h + 1) push(1, 1, 0);
            repeat (lw + 1) push(0, 1, 0);
        end
        if (!l) q[q.size()-1].rdy = 1;
    endtask

    task automatic latch();
        repeat (int'(rcnt) + 1) push(0, 1, 0);
        q[q.size()-1].dn = 1;
    endtask

    task automatic frame(input int np, input int lead, input bit hold);
        idle(lead + 1);
        for (int p = 0; p < np; p++) begin
            bit l = (p == np - 1);
            int st;
            hs(pd[p], l);
            st = q.size();
            bits(pd[p], l);
            if (l) begin
                latch();
            end else if (gp[p] > 0) begin
                idle(gp[p]);
            end else if (hold) begin
                for (int k = st; k < q.size() - 1; k++) begin
                    q[k].v = 1;
                    q[k].d = pd[p+1];
                    q[k].l = (p + 1 == np - 1);
                end
            end
        end
    endtask

    task automatic run_q(output int done_at, output int hs_last);
        done_at = -1;
        hs_last = -1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            chk($sformatf("line@%0d", i), 32'(line), 32'(q[i].line));
            chk($sformatf("busy@%0d", i), 32'(busy), 32'(q[i].busy));
            chk($sformatf("rdy@%0d", i), 32'(px.data_ready_out), 32'(q[i].rdy));
            chk($sformatf("done@%0d", i), 32'(done), 32'(q[i].dn));
            if (done && done_at < 0) done_at = i;
            if (q[i].v && px.data_ready_out) hs_last = i;
            px.data_valid_in = q[i].v;
            px.data_in       = q[i].d;
            px.last_in       = q[i].l;
        end
        q.delete();
    endtask

    task automatic set_cnt(input int a, input int b, input int c,
                           input int d, input int r);
        t0h = 8'(a); t0l = 8'(b); t1h = 8'(c); t1l = 8'(d);
        rcnt = 16'(r);
    endtask

    initial begin
        int da, hl, ndone, nhigh;
        px.data_valid_in = 0;
        px.data_in       = '0;
        px.last_in       = 0;
        set_cnt(2, 5, 5, 2, 10);

        repeat (3) @(negedge clk);
        chk("rst_line", 32'(line), 0);
        chk("rst_rdy", 32'(px.data_ready_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 0;
        #1;
        chk("post_rst_rdy", 32'(px.data_ready_out), 1);

        // Single pixel with mixed bit lengths.
        pd[0] = 24'h800001;
        frame(1, 0, 0);
        run_q(da, hl);
        chk("single_done", da, 227);
        chk("single_hs", hl, 0);

        // Back-to-back with valid held through the first pixel.
        pd[0] = 24'h800001; pd[1] = 24'h5A3C96; gp[0] = 0;
        frame(2, 0, 1);
        run_q(da, hl);
        chk("b2b_hs", hl, 216);

        // Underrun: five idle cycles between pixels.
        pd[0] = 24'h800001; pd[1] = 24'h00FF00; gp[0] = 5;
        frame(2, 0, 0);
        run_q(da, hl);
        chk("under_hs", hl, 221);

        // Minimum lengths everywhere.
        set_cnt(0, 0, 0, 0, 0);
        pd[0] = 24'hAAAAAA;
        frame(1, 0, 0);
        run_q(da, hl);
        chk("min_done", da, 49);

        // Randomised frames.
        for (int f = 0; f < 12; f++) begin
            set_cnt($urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 7));
            for (int p = 0; p < 4; p++) begin
                pd[p] = 24'($urandom);
                gp[p] = $urandom_range(0, 2);
            end
            frame($urandom_range(1, 3), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)));
            run_q(da, hl);
        end

        // Count change in the third cycle of a '1' high phase.
        set_cnt(2, 5, 5, 2, 10);
        ndone = 0; da = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            px.data_valid_in = (c == 0);
            px.data_in       = 24'hC00000;
            px.last_in       = 1;
            if (c == 3) t1h = 8'd1;
            #1;
            if (c == 6)  chk("mid_hi6", 32'(line), 1);
            if (c == 7)  chk("mid_lo7", 32'(line), 0);
            if (c == 10) chk("mid_hi10", 32'(line), 1);
            if (c == 11) chk("mid_hi11", 32'(line), 1);
            if (c == 12) chk("mid_lo12", 32'(line), 0);
            if (done && da < 0) da = c;
        end
        chk("mid_done", da, 223);

        // Reset during the low phase of bit 12.
        set_cnt(1, 1, 1, 1, 10);
        ndone = 0; nhigh = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            px.data_valid_in = (c == 0);
            px.data_in       = 24'($urandom);
            px.last_in       = 1;
            rst = (c == 47 || c == 48);
            #1;
            if (c == 46) chk("rst46_line", 32'(line), 1);
            if (c == 47) chk("rst47_line", 32'(line), 0);
            if (c == 47) chk("rst47_rdy", 32'(px.data_ready_out), 0);
            if (c == 48) chk("rst48_line", 32'(line), 0);
            if (c == 48) chk("rst48_busy", 32'(busy), 0);
            if (c == 49) chk("rst49_rdy", 32'(px.data_ready_out), 1);
            if (c == 49) chk("rst49_busy", 32'(busy), 0);
            if (c >= 47 && done) ndone++;
            if (c >= 48 && line) nhigh++;
        end
        chk("rst_no_done", ndone, 0);
        chk("rst_no_high", nhigh, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
